// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int CTRL_W_DEF    = 20;
  localparam int DATA_W_IFID   = 64;   // instruction + PC
  localparam int DATA_W_IDEX   = 133;  // operands, immediate, RegDst, PC, shift
  localparam int DATA_W_EXMEM  = 101;  // ALU result, store data, RegDst, PC
  localparam int DATA_W_MEMWB  = 133;  // ReadData, ADDR, RegDst, PC, SHIFT

  // Occupancy encoded by each state.
  function automatic logic [1:0] state_count(input state_t s);
    logic [1:0] c;
    case (s)
      EMPTY:   c = 2'd0;
      ONE:     c = 2'd1;
      FULL:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: control bundle plus payload, with load and
// control-only clear (a cleared control bundle reads as a NOP).
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_MEMWB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Entry storage; clear wins over load so a kill can never be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= {CTRL_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
    end else if (clr_ctrl) begin
      ctrl_r <= {CTRL_W{1'b0}};
    end else if (load) begin
      ctrl_r <= d_ctrl;
      data_r <= d_data;
    end
  end

  assign q_ctrl = ctrl_r;
  assign q_data = data_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake with a two-entry skid
// buffer, synchronous flush and bubble (zero-control) insertion.
// The head entry always lives in the main register; the skid register
// holds the second entry only while FULL.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = CTRL_W_DEF,
  parameter int DATA_W      = DATA_W_MEMWB,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [CTRL_W-1:0] I_CTRL,
  input  logic [DATA_W-1:0] I_DATA,
  input  logic              I_FLUSH,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [CTRL_W-1:0] O_CTRL,
  output logic [DATA_W-1:0] O_DATA,
  output logic [1:0]        O_COUNT
);

  state_t            state_r;
  state_t            next_state_s;
  logic              ready_s;
  logic              valid_s;
  logic              push_s;
  logic              pop_s;
  logic              main_load_s;
  logic              main_from_skid_s;
  logic              skid_load_s;
  logic              clr_ctrl_s;
  logic [CTRL_W-1:0] main_d_ctrl_s;
  logic [DATA_W-1:0] main_d_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;

  // Handshake flags come from the state register only, so O_READY has
  // no combinational path from I_READY.
  assign ready_s = (state_r != FULL);
  assign valid_s = (state_r != EMPTY);
  assign push_s  = I_VALID & ready_s;
  assign pop_s   = valid_s & I_READY;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and register load decode; flush overrides push and pop.
  always_comb begin
    next_state_s     = state_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    clr_ctrl_s       = 1'b0;
    if (I_FLUSH) begin
      next_state_s = EMPTY;
      clr_ctrl_s   = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            main_load_s  = 1'b1;
            next_state_s = ONE;
          end else begin
            next_state_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            main_load_s  = 1'b1;
            next_state_s = ONE;
          end else if (push_s) begin
            skid_load_s  = 1'b1;
            next_state_s = FULL;
          end else if (pop_s) begin
            next_state_s = EMPTY;
          end else begin
            next_state_s = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            next_state_s     = ONE;
          end else begin
            next_state_s = FULL;
          end
        end
        default: begin
          next_state_s = EMPTY;
          clr_ctrl_s   = 1'b1;
        end
      endcase
    end
  end

  // Main register source: the skid entry when draining FULL, else the input.
  always_comb begin
    main_d_ctrl_s = I_CTRL;
    main_d_data_s = I_DATA;
    if (main_from_skid_s) begin
      main_d_ctrl_s = skid_ctrl_s;
      main_d_data_s = skid_data_s;
    end else begin
      main_d_ctrl_s = I_CTRL;
      main_d_data_s = I_DATA;
    end
  end

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (main_load_s),
    .clr_ctrl (clr_ctrl_s),
    .d_ctrl   (main_d_ctrl_s),
    .d_data   (main_d_data_s),
    .q_ctrl   (main_ctrl_s),
    .q_data   (main_data_s)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (skid_load_s),
    .clr_ctrl (clr_ctrl_s),
    .d_ctrl   (I_CTRL),
    .d_data   (I_DATA),
    .q_ctrl   (skid_ctrl_s),
    .q_data   (skid_data_s)
  );

  assign O_READY = ready_s;
  assign O_VALID = valid_s;
  assign O_COUNT = state_count(state_r);
  assign O_DATA  = main_data_s;
  assign O_CTRL  = (ZERO_BUBBLE && !valid_s) ? {CTRL_W{1'b0}} : main_ctrl_s;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboard checks for pipe_skid_stage. Two instances share
// the stimulus: dut (ZERO_BUBBLE=1) and dut0 (ZERO_BUBBLE=0).
module tb_pipe_skid_stage;

  localparam int CW = 20;
  localparam int DW = 133;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          I_VALID;
  logic          I_FLUSH;
  logic          I_READY;
  logic [CW-1:0] I_CTRL;
  logic [DW-1:0] I_DATA;

  logic          o_ready, o_valid;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;
  logic          o_ready0, o_valid0;
  logic [CW-1:0] o_ctrl0;
  logic [DW-1:0] o_data0;
  logic [1:0]    o_count0;

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .ZERO_BUBBLE(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .I_VALID(I_VALID), .O_READY(o_ready),
    .I_CTRL(I_CTRL), .I_DATA(I_DATA), .I_FLUSH(I_FLUSH), .O_VALID(o_valid),
    .I_READY(I_READY), .O_CTRL(o_ctrl), .O_DATA(o_data), .O_COUNT(o_count)
  );

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .ZERO_BUBBLE(1'b0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .I_VALID(I_VALID), .O_READY(o_ready0),
    .I_CTRL(I_CTRL), .I_DATA(I_DATA), .I_FLUSH(I_FLUSH), .O_VALID(o_valid0),
    .I_READY(I_READY), .O_CTRL(o_ctrl0), .O_DATA(o_data0), .O_COUNT(o_count0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [CW-1:0] c, input logic [DW-1:0] d);
    I_VALID = v;
    I_READY = r;
    I_CTRL  = c;
    I_DATA  = d;
  endtask

  logic [CW+DW-1:0] sb[$];
  logic [CW+DW-1:0] ent;
  logic             hold, push, pop, rdy_before;

  initial begin
    RESET_N = 1'b0;
    I_FLUSH = 1'b0;
    drive(1'b0, 1'b0, 20'h0, 133'h0);
    repeat (3) step();

    // Reset values
    chk("rst_valid", 160'(o_valid), 160'd0);
    chk("rst_count", 160'(o_count), 160'd0);
    chk("rst_ready", 160'(o_ready), 160'd1);
    chk("rst_ctrl", 160'(o_ctrl), 160'd0);
    chk("rst_data", 160'(o_data), 160'd0);
    RESET_N = 1'b1;

    // Back-to-back streaming
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, CW'(i), DW'(i));
      step();
      chk($sformatf("stream_data%0d", i), 160'(o_data), 160'(i));
      chk($sformatf("stream_ctrl%0d", i), 160'(o_ctrl), 160'(i));
      chk($sformatf("stream_count%0d", i), 160'(o_count), 160'd1);
      chk($sformatf("stream_ready%0d", i), 160'(o_ready), 160'd1);
    end
    drive(1'b0, 1'b1, 20'h0, 133'h0);
    step();
    chk("drain_count", 160'(o_count), 160'd0);
    chk("drain_ctrl_bubble", 160'(o_ctrl), 160'd0);

    // Back-pressure into the skid register
    drive(1'b1, 1'b0, 20'hA, 133'hA);
    step();
    chk("bp_a_count", 160'(o_count), 160'd1);
    drive(1'b1, 1'b0, 20'hB, 133'hB);
    step();
    chk("bp_full_count", 160'(o_count), 160'd2);
    chk("bp_full_ready", 160'(o_ready), 160'd0);
    chk("bp_full_head", 160'(o_data), 160'hA);
    drive(1'b1, 1'b0, 20'hC, 133'hC);
    step();
    chk("bp_c_ignored_count", 160'(o_count), 160'd2);
    chk("bp_c_ignored_head", 160'(o_data), 160'hA);
    I_READY = 1'b1;
    step();
    chk("bp_out_b", 160'(o_data), 160'hB);
    chk("bp_out_b_count", 160'(o_count), 160'd1);
    step();
    chk("bp_out_c", 160'(o_data), 160'hC);
    chk("bp_out_c_count", 160'(o_count), 160'd1);
    I_VALID = 1'b0;
    step();
    chk("bp_empty", 160'(o_count), 160'd0);

    // Flush has priority over a simultaneous push
    drive(1'b1, 1'b0, 20'hFFFFF, 133'hD);
    step();
    drive(1'b1, 1'b0, 20'hFFFFF, 133'hE);
    step();
    chk("fl_full", 160'(o_count), 160'd2);
    I_FLUSH = 1'b1;
    drive(1'b1, 1'b0, 20'hFFFFF, 133'hF);
    step();
    I_FLUSH = 1'b0;
    chk("fl_valid", 160'(o_valid), 160'd0);
    chk("fl_ctrl", 160'(o_ctrl), 160'd0);
    chk("fl_ctrl_nozb", 160'(o_ctrl0), 160'd0);
    chk("fl_count", 160'(o_count), 160'd0);
    chk("fl_ready", 160'(o_ready), 160'd1);
    drive(1'b0, 1'b1, 20'h0, 133'h0);
    step();
    chk("fl_input_dropped", 160'(o_valid), 160'd0);

    // Bubble behaviour with and without ZERO_BUBBLE
    drive(1'b1, 1'b1, 20'h12345, 133'h55);
    step();
    chk("bub_ctrl", 160'(o_ctrl), 160'h12345);
    chk("bub_ctrl_nozb", 160'(o_ctrl0), 160'h12345);
    I_VALID = 1'b0;
    step();
    chk("bub_valid", 160'(o_valid), 160'd0);
    chk("bub_zero", 160'(o_ctrl), 160'd0);
    chk("bub_hold_nozb", 160'(o_ctrl0), 160'h12345);
    step();
    chk("bub_hold_nozb2", 160'(o_ctrl0), 160'h12345);

    // Asynchronous reset mid-operation
    drive(1'b1, 1'b0, 20'h21, 133'h21);
    step();
    drive(1'b1, 1'b0, 20'h22, 133'h22);
    step();
    chk("ar_full", 160'(o_count), 160'd2);
    I_VALID = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("ar_valid", 160'(o_valid), 160'd0);
    chk("ar_count", 160'(o_count), 160'd0);
    chk("ar_ctrl", 160'(o_ctrl), 160'd0);
    chk("ar_data", 160'(o_data), 160'd0);
    step();
    RESET_N = 1'b1;
    drive(1'b1, 1'b1, 20'h31, 133'h31);
    chk("ar_post_empty", 160'(o_valid), 160'd0);
    step();
    chk("ar_first_push", 160'(o_data), 160'h31);
    chk("ar_first_count", 160'(o_count), 160'd1);
    I_VALID = 1'b0;
    step();
    chk("ar_drained", 160'(o_count), 160'd0);

    // Random handshake against a scoreboard FIFO
    hold = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!hold) begin
        I_VALID = 1'($urandom_range(1, 0));
        I_CTRL  = CW'($urandom);
        I_DATA  = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
      end
      I_READY = 1'($urandom_range(1, 0));
      #1;
      rdy_before = o_ready;
      I_READY = ~I_READY;
      #1;
      chk("rnd_ready_indep", 160'(o_ready), 160'(rdy_before));
      I_READY = ~I_READY;
      #1;
      chk("rnd_count", 160'(o_count), 160'(sb.size()));
      chk("rnd_ready", 160'(o_ready), 160'(sb.size() != 2));
      if (sb.size() != 0) begin
        ent = sb[0];
        chk("rnd_head", 160'({o_ctrl, o_data}), 160'(ent));
      end
      push = I_VALID && (sb.size() != 2);
      pop  = I_READY && (sb.size() != 0);
      step();
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({I_CTRL, I_DATA});
      hold = I_VALID && !push;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
